hash_out_serializer: RTL and testbench
======================================

Name: hash_out_serializer

Overview:
- Transmit side of the byte-serial host interface; the counterpart to the command/data byte receiver.
- Captures the final BLAKE2b chaining state h[0..7] (64 bytes) in one cycle when the core signals completion.
- Streams the first nn bytes to the host, one byte per handshake, little-endian, with a last-byte marker.
- Sits between the compression core and the io_intf hash output pins; replaces the current direct hash_i pass-through.

Parameters:
- DIGEST_BYTES, 64, maximum digest length in bytes; capture buffer width is DIGEST_BYTES*8.
- CNT_W, 7, width of the byte counter; must satisfy 2**CNT_W > DIGEST_BYTES.

Ports:
- clk  input  1  single clock.
- nreset  input  1  synchronous reset, active-low.
- res_v_i  input  1  core result valid; single-cycle pulse.
- res_i  input  DIGEST_BYTES*8  final h state; byte 0 is res_i[7:0].
- nn_i  input  8  digest length in bytes, from the config block; sampled on capture.
- res_ready_o  output  1  serializer idle and able to capture.
- res_drop_o  output  1  one-cycle pulse: res_v_i arrived while busy and was discarded.
- hash_v_o  output  1  output byte valid.
- hash_o  output  8  output byte.
- hash_last_o  output  1  current byte is the final digest byte.
- hash_ready_i  input  1  host accepts the byte.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, on nreset; all state is sampled on posedge clk.
- Reset values: FSM = IDLE, res_ready_o = 1, res_drop_o = 0, hash_v_o = 0, hash_last_o = 0, hash_o = 0, counter = 0. Buffer contents are don't-care unless HASH_OUT_ZEROIZE_EN is defined.
- FSM states: IDLE, SEND.
- IDLE -> SEND when res_v_i = 1.
  - Capture res_i into the buffer.
  - Length: len = nn_i if 1 <= nn_i <= DIGEST_BYTES, otherwise len = DIGEST_BYTES (clamp).
  - Counter loads len-1.
- Capture latency: res_v_i in cycle T gives hash_v_o = 1 and hash_o = res_i[7:0] in cycle T+1. All outputs are registered.
- SEND output handshake: a byte transfers in any cycle with hash_v_o & hash_ready_i.
  - On transfer: buffer shifts right 8 bits, hash_o takes the next byte, counter decrements.
  - While hash_v_o & ~hash_ready_i: hash_o, hash_last_o and hash_v_o hold stable.
- hash_last_o = 1 exactly when the counter is 0 in SEND.
- Transfer with hash_last_o = 1 -> IDLE next cycle; hash_v_o = 0 and hash_last_o = 0 that cycle.
- Throughput: one byte per cycle while hash_ready_i is held high, so len bytes take len cycles.
- res_ready_o = (state == IDLE). It is state-derived, not combinational from hash_ready_i.
- Minimum gap between digests: one IDLE cycle. A res_v_i arriving in the same cycle as the last-byte transfer is dropped.
- res_v_i while in SEND: ignored; res_drop_o pulses the next cycle; the current stream is undisturbed.
- nn_i changing during SEND: no effect; len is latched at capture.
- nreset low mid-stream: next cycle returns to reset values; the partial digest is abandoned with no last marker.
- Counter arithmetic is CNT_W wide and never underflows, because the decrement happens only in SEND with counter > 0.

Optional Feature:
- Macro: HASH_OUT_ZEROIZE_EN.
- Defined:
  - The buffer shifts in zeros and is cleared to 0 on reset and on the SEND -> IDLE transition.
  - hash_o is forced to 0 whenever hash_v_o = 0.
  - No digest bytes remain in flops after transmission.
- Undefined:
  - The buffer is not reset; stale bytes remain after the stream.
  - hash_o holds the last transmitted byte while idle.
  - Fewer reset flops.

Decomposition:
- Shared package blake2_pkg:
  - DIGEST_BYTES_MAX = 64.
  - Serializer state enum {IDLE, SEND}.
  - Command encoding constants CMD_CONF/START/DATA/LAST, so transmit and receive sides share one definition.
- No sub-module; the FSM, counter and shift buffer form one module. io_intf instantiates it in place of the hash pass-through.

Test Plan:
- nn_i = 32, res_i bytes = 0x00..0x3F, hash_ready_i tied 1: 32 consecutive hash_v_o cycles starting T+1 carry 0x00..0x1F; hash_last_o only on 0x1F; res_ready_o back to 1 at T+33.
- nn_i = 64, hash_ready_i toggling 1,0,0,1 pattern: 64 bytes in order; no byte repeated or skipped; hash_o and hash_last_o stable during stalls.
- nn_i = 0, then nn_i = 200: each clamps to 64 bytes out; hash_last_o on byte 63.
- Second res_v_i 5 cycles into a 16-byte stream: res_drop_o pulses once; original 16 bytes intact; the dropped result is never emitted.
- nreset low at byte 10 of 64: next cycle hash_v_o = 0 and res_ready_o = 1; a new capture then streams correctly from byte 0.
- With HASH_OUT_ZEROIZE_EN defined: after the last byte, the buffer reads all-zero and hash_o = 0 while idle.

Source files
------------

// File: rtl/blake2_pkg.sv
// Shared BLAKE2 host-interface definitions: digest size, serializer states, command byte encodings.
package blake2_pkg;

  localparam int DIGEST_BYTES_MAX = 64;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  localparam logic [1:0] CMD_CONF  = 2'd0;
  localparam logic [1:0] CMD_START = 2'd1;
  localparam logic [1:0] CMD_DATA  = 2'd2;
  localparam logic [1:0] CMD_LAST  = 2'd3;

  // nn of 0 or above max_len is treated as a request for the full digest.
  function automatic logic len_in_range(input logic [7:0] nn, input int max_len);
    return (nn != 8'd0) && (int'(nn) <= max_len);
  endfunction

endpackage

// File: rtl/hash_out_serializer.sv
// Captures the final h state on res_v_i and streams nn bytes LSB-first; first byte one cycle after capture,
// holds the byte stable while hash_ready_i is low. HASH_OUT_ZEROIZE_EN clears the buffer on reset and after each stream.
module hash_out_serializer
  import blake2_pkg::*;
#(
  parameter int DIGEST_BYTES = DIGEST_BYTES_MAX,
  parameter int CNT_W        = 7
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      res_v_i,
  input  logic [DIGEST_BYTES*8-1:0] res_i,
  input  logic [7:0]                nn_i,
  output logic                      res_ready_o,
  output logic                      res_drop_o,
  output logic                      hash_v_o,
  output logic [7:0]                hash_o,
  output logic                      hash_last_o,
  input  logic                      hash_ready_i
);

  localparam int BUF_W = DIGEST_BYTES * 8;

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [7:0]       hash_q, hash_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] len_m1;
  logic             xfer;

  always_comb begin
    len_m1 = CNT_W'(DIGEST_BYTES - 1);
    if (len_in_range(nn_i, DIGEST_BYTES)) begin
      len_m1 = CNT_W'(nn_i - 8'd1);
    end
  end

  assign xfer = vld_q & hash_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    hash_d  = hash_q;
    vld_d   = vld_q;
    last_d  = last_q;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (res_v_i) begin
          state_d = SEND;
          hash_d  = res_i[7:0];
          buf_d   = res_i >> 8;
          cnt_d   = len_m1;
          vld_d   = 1'b1;
          last_d  = (len_m1 == '0);
        end
      end
      SEND: begin
        drop_d = res_v_i;
        if (xfer) begin
          if (last_q) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            last_d  = 1'b0;
`ifdef HASH_OUT_ZEROIZE_EN
            buf_d   = '0;
            hash_d  = '0;
`endif
          end else begin
            hash_d = buf_q[7:0];
            buf_d  = buf_q >> 8;
            cnt_d  = cnt_q - CNT_W'(1);
            last_d = (cnt_q == CNT_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hash_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hash_q  <= hash_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
    end
  end

`ifdef HASH_OUT_ZEROIZE_EN
  always_ff @(posedge clk) begin
    if (!nreset) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end
`else
  // Digest bytes need no reset value; they are always loaded before use.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
`endif

  assign res_ready_o = (state_q == IDLE);
  assign res_drop_o  = drop_q;
  assign hash_v_o    = vld_q;
  assign hash_o      = hash_q;
  assign hash_last_o = last_q;

endmodule

// File: tb/tb_hash_out_serializer.sv
// Directed bench for hash_out_serializer: streaming, stalls, length clamping, drops and mid-stream reset.
module tb_hash_out_serializer;

  localparam int DB = 64;

  logic            clk = 1'b0;
  logic            nreset;
  logic            res_v_i;
  logic [DB*8-1:0] res_i;
  logic [7:0]      nn_i;
  logic            res_ready_o;
  logic            res_drop_o;
  logic            hash_v_o;
  logic [7:0]      hash_o;
  logic            hash_last_o;
  logic            hash_ready_i;

  logic [DB*8-1:0] pat_a;
  logic [DB*8-1:0] pat_b;

  int n_cmp  = 0;
  int n_fail = 0;

  hash_out_serializer #(.DIGEST_BYTES(DB), .CNT_W(7)) dut (
    .clk          (clk),
    .nreset       (nreset),
    .res_v_i      (res_v_i),
    .res_i        (res_i),
    .nn_i         (nn_i),
    .res_ready_o  (res_ready_o),
    .res_drop_o   (res_drop_o),
    .hash_v_o     (hash_v_o),
    .hash_o       (hash_o),
    .hash_last_o  (hash_last_o),
    .hash_ready_i (hash_ready_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] exp_byte);
    chk1({tag, "_vld"}, hash_v_o, 1'b0);
    chk1({tag, "_last"}, hash_last_o, 1'b0);
    chk1({tag, "_rdy"}, res_ready_o, 1'b1);
`ifdef HASH_OUT_ZEROIZE_EN
    chk8({tag, "_byte"}, hash_o, 8'h00);
    chk1({tag, "_bufzero"}, (dut.buf_q == '0), 1'b1);
`else
    chk8({tag, "_byte"}, hash_o, exp_byte);
`endif
  endtask

  // Capture pat_a with the given nn and expect len bytes 0..len-1 back-to-back.
  task automatic stream(input string tag, input logic [7:0] nn, input int len);
    nn_i    = nn;
    res_v_i = 1'b1;
    step();
    res_v_i = 1'b0;
    for (int i = 0; i < len; i++) begin
      chk1({tag, "_vld"}, hash_v_o, 1'b1);
      chk8({tag, "_byte"}, hash_o, 8'(i));
      chk1({tag, "_last"}, hash_last_o, (i == len - 1));
      chk1({tag, "_busy"}, res_ready_o, 1'b0);
      step();
    end
    chk_idle({tag, "_end"}, 8'(len - 1));
  endtask

  initial begin
    int idx;
    int cyc;
    for (int i = 0; i < DB; i++) begin
      pat_a[8*i +: 8] = 8'(i);
      pat_b[8*i +: 8] = 8'(8'h80 + i);
    end
    nreset       = 1'b0;
    res_v_i      = 1'b0;
    res_i        = pat_a;
    nn_i         = 8'd32;
    hash_ready_i = 1'b1;
    step();
    step();
    chk1("rst_vld", hash_v_o, 1'b0);
    chk1("rst_last", hash_last_o, 1'b0);
    chk1("rst_rdy", res_ready_o, 1'b1);
    chk1("rst_drop", res_drop_o, 1'b0);
    chk8("rst_byte", hash_o, 8'h00);
    nreset = 1'b1;
    step();

    // 32-byte stream at full rate
    stream("nn32", 8'd32, 32);

    // 64-byte stream with ready pattern 1,0,0,1
    nn_i    = 8'd64;
    res_v_i = 1'b1;
    step();
    res_v_i = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 64 && cyc < 400) begin
      hash_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      chk1("stall_vld", hash_v_o, 1'b1);
      chk8("stall_byte", hash_o, 8'(idx));
      chk1("stall_last", hash_last_o, (idx == 63));
      step();
      if (hash_ready_i) idx++;
      cyc++;
    end
    chk1("stall_done", (idx == 64), 1'b1);
    hash_ready_i = 1'b1;
    chk_idle("stall_end", 8'd63);

    // Length clamping
    stream("nn0", 8'd0, 64);
    stream("nn200", 8'd200, 64);

    // Result arriving mid-stream is dropped; nn change mid-stream ignored
    nn_i    = 8'd16;
    res_v_i = 1'b1;
    step();
    res_v_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk1("drop_vld", hash_v_o, 1'b1);
      chk8("drop_byte", hash_o, 8'(i));
      chk1("drop_last", hash_last_o, (i == 15));
      chk1("drop_pulse", res_drop_o, (i == 6));
      if (i == 5) begin
        res_v_i = 1'b1;
        res_i   = pat_b;
        nn_i    = 8'd3;
      end else begin
        res_v_i = 1'b0;
      end
      step();
    end
    chk_idle("drop_end", 8'd15);
    res_i = pat_a;
    for (int i = 0; i < 3; i++) begin
      chk1("drop_quiet_vld", hash_v_o, 1'b0);
      chk1("drop_quiet_pulse", res_drop_o, 1'b0);
      step();
    end

    // Reset at byte 10 of a 64-byte stream, then a fresh 8-byte stream
    nn_i    = 8'd64;
    res_v_i = 1'b1;
    step();
    res_v_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk8("pre_rst_byte", hash_o, 8'(i));
      step();
    end
    chk8("pre_rst_b10", hash_o, 8'd10);
    nreset = 1'b0;
    step();
    chk1("mid_rst_vld", hash_v_o, 1'b0);
    chk1("mid_rst_rdy", res_ready_o, 1'b1);
    chk1("mid_rst_last", hash_last_o, 1'b0);
    chk8("mid_rst_byte", hash_o, 8'h00);
    nreset = 1'b1;
    step();
    stream("post_rst", 8'd8, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
